// File: rtl/cosim_ep_msg_serializer_if.sv
// Message-in / beat-out handshake bundle for the cosim endpoint message serializer.
interface cosim_ep_msg_serializer_if #(
   parameter int unsigned MSG_BITS  = 72,
   parameter int unsigned BEAT_BITS = 32
);
   localparam int unsigned NUM_BEATS_RAW = (MSG_BITS + BEAT_BITS - 1) / BEAT_BITS;
   localparam int unsigned NUM_BEATS     = (NUM_BEATS_RAW < 1) ? 1 : NUM_BEATS_RAW;
   localparam int unsigned IDX_W         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   logic                 MsgValid;
   logic                 MsgReady;
   logic [MSG_BITS-1:0]  MsgData;
   logic                 BeatValid;
   logic                 BeatReady;
   logic [BEAT_BITS-1:0] BeatData;
   logic                 BeatLast;
   logic [IDX_W-1:0]     BeatIdx;
   logic [31:0]          MsgCount;

   // Endpoint / DUT side: offers messages and accepts beats
   modport master (
      output MsgValid, MsgData, BeatReady,
      input  MsgReady, BeatValid, BeatData, BeatLast, BeatIdx, MsgCount
   );

   // Serializer side
   modport slave (
      input  MsgValid, MsgData, BeatReady,
      output MsgReady, BeatValid, BeatData, BeatLast, BeatIdx, MsgCount
   );
endinterface

// File: rtl/cosim_ep_msg_serializer.sv
// Splits each wide endpoint message into LSB-first, zero-padded narrow beats.
module cosim_ep_msg_serializer #(
   parameter int unsigned MSG_BITS  = 72,
   parameter int unsigned BEAT_BITS = 32
) (
   input logic                      clk,
   input logic                      rst,
   cosim_ep_msg_serializer_if.slave bus
);
   localparam int unsigned NUM_BEATS_RAW = (MSG_BITS + BEAT_BITS - 1) / BEAT_BITS;
   localparam int unsigned NUM_BEATS     = (NUM_BEATS_RAW < 1) ? 1 : NUM_BEATS_RAW;
   localparam int unsigned IDX_W         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int unsigned PAD_BITS      = NUM_BEATS * BEAT_BITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);
   localparam logic        SINGLE_BEAT   = (NUM_BEATS == 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                              state;
   logic [NUM_BEATS-1:0][BEAT_BITS-1:0] hold;
   logic [NUM_BEATS-1:0][BEAT_BITS-1:0] msg_pad;
   logic                                beat_valid;
   logic                                beat_last;
   logic [IDX_W-1:0]                    beat_idx;
   logic [IDX_W-1:0]                    idx_nxt;
   logic [BEAT_BITS-1:0]                beat_data;
   logic [31:0]                         msg_count;
   logic                                beat_fire;
   logic                                msg_ready;
   logic                                msg_fire;

   // Zero-extend the message so the final beat reads zeros above MSG_BITS
   assign msg_pad = PAD_BITS'(bus.MsgData);
   assign idx_nxt = beat_idx + IDX_W'(1);

   // Handshakes; a new message may enter on the same edge the last beat leaves
   assign beat_fire = beat_valid && bus.BeatReady;
   assign msg_ready = !rst && ((state == IDLE) || (beat_fire && beat_last));
   assign msg_fire  = bus.MsgValid && msg_ready;

   // Serializer FSM with registered beat outputs and delivered-message counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold       <= '0;
         beat_valid <= 1'b0;
         beat_last  <= 1'b0;
         beat_idx   <= '0;
         beat_data  <= '0;
         msg_count  <= '0;
      end else begin
         if (beat_fire && beat_last) begin
            msg_count <= msg_count + 32'd1;
         end
         if (msg_fire) begin
            state      <= SEND;
            hold       <= msg_pad;
            beat_valid <= 1'b1;
            beat_idx   <= '0;
            beat_data  <= msg_pad[0];
            beat_last  <= SINGLE_BEAT;
         end else if (beat_fire) begin
            if (beat_last) begin
               state      <= IDLE;
               beat_valid <= 1'b0;
            end else begin
               beat_idx  <= idx_nxt;
               beat_data <= hold[idx_nxt];
               beat_last <= (idx_nxt == LAST_IDX);
            end
         end
      end
   end

   assign bus.MsgReady  = msg_ready;
   assign bus.BeatValid = beat_valid;
   assign bus.BeatData  = beat_data;
   assign bus.BeatLast  = beat_last;
   assign bus.BeatIdx   = beat_idx;
   assign bus.MsgCount  = msg_count;
endmodule
